// File: rtl/wordcount_kernel_ctrl_mc.sv
// Multi-channel ap_ctrl start/done controller for the wordcount engines.
// Launches the enabled channels together, gathers their done pulses, and guards the run with a watchdog.
module wordcount_kernel_ctrl_mc #(
    parameter int C_NUM_CHANNELS    = 4,
    parameter int C_CYCLE_CNT_WIDTH = 64,
    parameter int C_TIMEOUT_WIDTH   = 32,
    parameter int C_CHAIN_MODE      = 0
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         ap_start,
    input  logic                         ap_continue,
    output logic                         ap_idle,
    output logic                         ap_ready,
    output logic                         ap_done,
    input  logic [C_NUM_CHANNELS-1:0]    ch_enable,
    input  logic [C_TIMEOUT_WIDTH-1:0]   timeout_cycles,
    output logic [C_NUM_CHANNELS-1:0]    ch_start,
    input  logic [C_NUM_CHANNELS-1:0]    ch_done,
    output logic [C_NUM_CHANNELS-1:0]    done_status,
    output logic                         timeout_err,
    output logic [C_CYCLE_CNT_WIDTH-1:0] cycle_count
);
    // state  | meaning
    // IDLE   | waiting for a start edge; status of the last run is held
    // LAUNCH | one-cycle kick of the enabled channels, status cleared
    // RUN    | collecting done bits, counting cycles, watchdog armed
    // DONE   | run complete; one cycle, or until ap_continue in chain mode
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

    localparam logic [C_CYCLE_CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [C_TIMEOUT_WIDTH-1:0]   WD_ONE  = 1;

    state_t                         state_q, state_d;
    logic                           ap_start_q;
    logic [C_NUM_CHANNELS-1:0]      en_q, en_d;
    logic [C_TIMEOUT_WIDTH-1:0]     wdog_q, wdog_d;
    logic                           wdog_en_q, wdog_en_d;
    logic [C_NUM_CHANNELS-1:0]      done_status_q, done_status_d;
    logic                           timeout_err_q, timeout_err_d;
    logic [C_CYCLE_CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
    logic                           start_pulse;
    logic [C_NUM_CHANNELS-1:0]      done_next;

    always_ff @(posedge ap_clk) begin
        ap_start_q <= ap_start;
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q       <= S_IDLE;
            en_q          <= '0;
            wdog_q        <= '0;
            wdog_en_q     <= 1'b0;
            done_status_q <= '0;
            timeout_err_q <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            en_q          <= en_d;
            wdog_q        <= wdog_d;
            wdog_en_q     <= wdog_en_d;
            done_status_q <= done_status_d;
            timeout_err_q <= timeout_err_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign start_pulse = ap_start & ~ap_start_q;
    assign done_next   = done_status_q | (ch_done & en_q);

    always_comb begin
        state_d       = state_q;
        en_d          = en_q;
        wdog_d        = wdog_q;
        wdog_en_d     = wdog_en_q;
        done_status_d = done_status_q;
        timeout_err_d = timeout_err_q;
        cycle_count_d = cycle_count_q;
        case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    en_d      = ch_enable;
                    wdog_d    = timeout_cycles;
                    wdog_en_d = |timeout_cycles;
                    if (|ch_enable) begin
                        state_d = S_LAUNCH;
                    end else begin
                        state_d       = S_DONE;
                        done_status_d = '0;
                        cycle_count_d = '0;
                        timeout_err_d = 1'b0;
                    end
                end
            end
            S_LAUNCH: begin
                state_d       = S_RUN;
                done_status_d = '0;
                cycle_count_d = '0;
                timeout_err_d = 1'b0;
            end
            S_RUN: begin
                done_status_d = done_next;
                if (!(&cycle_count_q)) begin
                    cycle_count_d = cycle_count_q + CNT_ONE;
                end
                if (wdog_q != '0) begin
                    wdog_d = wdog_q - WD_ONE;
                end
                // Watchdog terminal count lands on the same cycle as cycle_count + 1 == limit
                if (done_next == en_q) begin
                    state_d = S_DONE;
                end else if (wdog_en_q && (wdog_q == WD_ONE)) begin
                    state_d       = S_DONE;
                    timeout_err_d = 1'b1;
                end
            end
            S_DONE: begin
                if ((C_CHAIN_MODE == 0) || ap_continue) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ap_idle     = (state_q == S_IDLE);
    assign ap_ready    = (state_q == S_LAUNCH);
    assign ap_done     = (state_q == S_DONE);
    assign ch_start    = (state_q == S_LAUNCH) ? en_q : '0;
    assign done_status = done_status_q;
    assign timeout_err = timeout_err_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: doc/wordcount_kernel_ctrl_mc.md
Name: wordcount_kernel_ctrl_mc

Overview:
- Multi-channel successor of the wordcount kernel's ap_ctrl start/done logic. Sits between the host ap_ctrl signals and N independent wordcount engines.
- On a host start it launches the enabled engines together and collects their done pulses. It then reports ap_done, ap_ready and ap_idle.
- Added over the single-channel logic: a per-channel enable mask, an ap_ctrl_chain mode (ap_continue), a run-cycle counter, and a watchdog timeout.

Parameters:
- C_NUM_CHANNELS, 4: number of engine channels (1..32).
- C_CYCLE_CNT_WIDTH, 64: width of the run-cycle counter.
- C_TIMEOUT_WIDTH, 32: width of the watchdog limit.
- C_CHAIN_MODE, 0: 0 = ap_ctrl_hs (ap_done is a 1-cycle pulse); 1 = ap_ctrl_chain (ap_done held until ap_continue).

Ports:
- ap_clk  in  1  clock.
- areset  in  1  synchronous, active-high reset, sampled on ap_clk.
- ap_start  in  1  host start; acted on at its rising edge.
- ap_continue  in  1  host acknowledge of done; used only when C_CHAIN_MODE=1.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  1-cycle pulse when the start is accepted.
- ap_done  out  1  run complete.
- ch_enable  in  C_NUM_CHANNELS  channels taking part in the run; sampled at start.
- timeout_cycles  in  C_TIMEOUT_WIDTH  watchdog limit; 0 disables the watchdog; sampled at start.
- ch_start  out  C_NUM_CHANNELS  per-channel 1-cycle kick.
- ch_done  in  C_NUM_CHANNELS  per-channel done pulse, or level.
- done_status  out  C_NUM_CHANNELS  channels that have completed in the current or last run.
- timeout_err  out  1  sticky: the last run ended because the watchdog expired.
- cycle_count  out  C_CYCLE_CNT_WIDTH  number of cycles spent in RUN during the last or current run.

Behaviour:
- All outputs are registered or decoded from registered state; there is no combinational path from input to output.
- Reset values: state IDLE, ap_idle=1; ap_ready, ap_done, ch_start, done_status, timeout_err and cycle_count all 0.
- Reset asserted in any state forces the reset values on the next edge. A ch_start in flight is dropped.
- Start edge detection:
  - ap_start_r <= ap_start on every cycle, including during reset.
  - start_pulse = ap_start & ~ap_start_r.
  - A start_pulse outside IDLE is ignored and is not queued.
- IDLE:
  - On start_pulse: latch en_q <= ch_enable and to_q <= timeout_cycles.
  - If ch_enable != 0, go to LAUNCH.
  - If ch_enable == 0, go straight to DONE, with done_status=0 and cycle_count=0.
- LAUNCH (exactly 1 cycle):
  - ch_start = en_q and ap_ready = 1 for this cycle only.
  - Clear done_status, cycle_count and timeout_err.
  - Next state is RUN.
- RUN:
  - Each cycle: done_status <= done_status | (ch_done & en_q).
  - cycle_count increments by 1 per cycle and saturates at all-ones (no wrap).
  - ch_done is ignored in every state except RUN.
  - ch_done bits of disabled channels are ignored.
  - A done bit seen on the first RUN cycle counts.
- RUN exit conditions:
  - Complete when (done_status | (ch_done & en_q)) == en_q. Go to DONE; done_status takes its final value on the same edge.
  - Timeout when to_q != 0 and cycle_count + 1 == to_q. Set timeout_err and go to DONE.
  - If completion and timeout occur on the same cycle, completion wins and timeout_err stays 0.
- DONE:
  - ap_done = 1 and ap_idle = 0.
  - With C_CHAIN_MODE=0: DONE lasts 1 cycle, then IDLE.
  - With C_CHAIN_MODE=1: hold DONE until ap_continue = 1, then IDLE on the next edge. If ap_continue is already high on entry, DONE lasts 1 cycle.
- Status hold: done_status, cycle_count and timeout_err hold their values through IDLE until the next LAUNCH.
- Back-to-back runs: a start_pulse in the first IDLE cycle after DONE is accepted.
- Minimum latency: start edge → ch_start takes 2 edges (IDLE→LAUNCH). All enabled channels returning done on the first RUN cycle gives ap_done 1 cycle later.

Test Plan:
- Reset, then N=4, ch_enable=4'b1111, timeout=0, start. Channels return done at RUN cycles 3, 7, 5, 10 → ch_start=4'b1111 for 1 cycle; ap_done pulses once, 1 cycle after cycle 10; cycle_count=10; done_status=4'b1111; ap_idle=1 afterwards.
- ch_enable=4'b0101 with ch_done pulsing on all four bits → completion occurs only when bits 0 and 2 are both done; done_status=4'b0101.
- timeout_cycles=20 with channel 3 never done → ap_done after 20 RUN cycles; timeout_err=1; done_status=4'b0111. Then start with completion and timeout on the same cycle → timeout_err=0.
- C_CHAIN_MODE=1 with ap_continue held low for 15 cycles → ap_done stays high for 15 cycles and a start during that time is ignored. ap_continue=1 → IDLE; a new start is accepted.
- ch_enable=0 then start → ap_done 2 cycles after the start edge; no ch_start; cycle_count=0.
- ap_start held high across a run → exactly one run. areset mid-RUN → all outputs return to their reset values next cycle and later ch_done pulses are ignored.
